// File: rtl/zigzag_agu.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_agu
// Brief    : Zig-zag (anti-diagonal) address generator for the bit-serial
//            multiply datapath. Walks every (weight bit, data bit) pair of a
//            pw x pd product one diagonal at a time. Each beat carries a
//            shift flag, a two's-complement sign flag and a last flag over a
//            valid/ready stream. A start/busy/done job handshake frames it.
// Options  : ZIGZAG_MSB_FIRST_EN - walk diagonals from k=pw+pd-2 down to 0.
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_agu #(
    parameter int BWP = 4
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [BWP-1:0] pw,
    input  logic [BWP-1:0] pd,
    input  logic           sw,
    input  logic           sd,
    output logic           busy,
    output logic           valid,
    input  logic           ready,
    output logic [BWP-1:0] offw,
    output logic [BWP-1:0] offd,
    output logic           sh,
    output logic           neg,
    output logic           last,
    output logic           done
);

    // One extra bit so k = offw + offd and the bounds never wrap.
    localparam int KW = BWP + 1;
    localparam logic [KW-1:0]  c_one_k = KW'(1);
    localparam logic [BWP-1:0] c_one_w = BWP'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         r_state;
    logic [BWP-1:0] r_pw, r_pd;
    logic           r_sw, r_sd;
    logic [KW-1:0]  r_k;
    logic [BWP-1:0] r_offw, r_offd;
    logic           r_sh, r_neg, r_last;
    logic           r_busy, r_valid, r_done;

    // Successor of the current beat, from the latched job parameters.
    logic [KW-1:0]  w_pw_m1, w_pd_m1;
    logic           w_in_diag;
    logic [KW-1:0]  w_k_nxt, w_dw, w_dd, w_k_adv;
    logic [BWP-1:0] w_offw_nxt, w_offd_nxt;
    logic           w_neg_nxt, w_last_nxt;

    assign w_pw_m1   = {1'b0, r_pw} - c_one_k;
    assign w_pd_m1   = {1'b0, r_pd} - c_one_k;
    // Stay on this diagonal while neither bound has been reached.
    assign w_in_diag = (r_offw != '0) && ({1'b0, r_offd} != w_pd_m1);
`ifdef ZIGZAG_MSB_FIRST_EN
    assign w_k_nxt   = r_k - c_one_k;
`else
    assign w_k_nxt   = r_k + c_one_k;
`endif
    // A new diagonal starts at the highest legal weight index.
    assign w_dw       = (w_k_nxt > w_pw_m1) ? w_pw_m1 : w_k_nxt;
    assign w_dd       = w_k_nxt - w_dw;
    assign w_k_adv    = w_in_diag ? r_k : w_k_nxt;
    assign w_offw_nxt = w_in_diag ? (r_offw - c_one_w) : w_dw[BWP-1:0];
    assign w_offd_nxt = w_in_diag ? (r_offd + c_one_w) : w_dd[BWP-1:0];
    assign w_neg_nxt  = (r_sw && ({1'b0, w_offw_nxt} == w_pw_m1)) ^
                        (r_sd && ({1'b0, w_offd_nxt} == w_pd_m1));
`ifdef ZIGZAG_MSB_FIRST_EN
    assign w_last_nxt = (w_offw_nxt == '0) && (w_offd_nxt == '0);
`else
    assign w_last_nxt = ({1'b0, w_offw_nxt} == w_pw_m1) &&
                        ({1'b0, w_offd_nxt} == w_pd_m1);
`endif

    // First beat of a job, taken straight from the start-time inputs.
    logic [KW-1:0]  w_pw_in_m1, w_pd_in_m1, w_k0;
    logic [BWP-1:0] w_ow0, w_od0;
    logic           w_neg0, w_last0, w_zero_job;

    assign w_pw_in_m1 = {1'b0, pw} - c_one_k;
    assign w_pd_in_m1 = {1'b0, pd} - c_one_k;
`ifdef ZIGZAG_MSB_FIRST_EN
    assign w_ow0 = pw - c_one_w;
    assign w_od0 = pd - c_one_w;
    assign w_k0  = w_pw_in_m1 + w_pd_in_m1;
`else
    assign w_ow0 = '0;
    assign w_od0 = '0;
    assign w_k0  = '0;
`endif
    assign w_neg0     = (sw && ({1'b0, w_ow0} == w_pw_in_m1)) ^
                        (sd && ({1'b0, w_od0} == w_pd_in_m1));
    assign w_last0    = (pw == c_one_w) && (pd == c_one_w);
    assign w_zero_job = (pw == '0) || (pd == '0);

    // MSBs of the diagonal-start values are bounded below 2^BWP by construction.
    logic w_unused;
    assign w_unused = &{1'b0, w_dw[BWP], w_dd[BWP]};

    // Job FSM; every output is a register so nothing passes input to output.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_pw    <= '0;
            r_pd    <= '0;
            r_sw    <= 1'b0;
            r_sd    <= 1'b0;
            r_k     <= '0;
            r_offw  <= '0;
            r_offd  <= '0;
            r_sh    <= 1'b0;
            r_neg   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        if (w_zero_job) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_pw    <= pw;
                            r_pd    <= pd;
                            r_sw    <= sw;
                            r_sd    <= sd;
                            r_k     <= w_k0;
                            r_offw  <= w_ow0;
                            r_offd  <= w_od0;
                            r_sh    <= 1'b0;
                            r_neg   <= w_neg0;
                            r_last  <= w_last0;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_valid && ready) begin
                        if (r_last) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_sh    <= 1'b0;
                            r_neg   <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_k    <= w_k_adv;
                            r_offw <= w_offw_nxt;
                            r_offd <= w_offd_nxt;
                            r_sh   <= ~w_in_diag;
                            r_neg  <= w_neg_nxt;
                            r_last <= w_last_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign offw  = r_offw;
    assign offd  = r_offd;
    assign sh    = r_sh;
    assign neg   = r_neg;
    assign last  = r_last;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/zigzag_agu.md
Name: zigzag_agu

Overview:
Parametrised zig-zag address generator for the bit-serial multiply datapath. It walks every (weight bit, data bit) pair of a pw x pd precision product one anti-diagonal at a time, so each diagonal has constant significance k = offw + offd. It emits one pair per beat over a valid/ready stream. Per beat it also emits a shift flag for the shift-accumulator, a sign flag for two's-complement operands, and a last flag. Compared with the earlier fixed-width generator it adds: a start/busy/done handshake, correct clamping on both precision bounds, backpressure, and signed-operand support.

Parameters:
BWP, 4, bitwidth of the precision inputs and offset outputs; precisions 1..2^BWP-1 are supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
clr  input  1  reset, asynchronous, active-high
start  input  1  job request; accepted only when busy=0
pw  input  BWP  weight precision in bits; sampled on start acceptance
pd  input  BWP  data precision in bits; sampled on start acceptance
sw  input  1  weight operand is signed; sampled on start acceptance
sd  input  1  data operand is signed; sampled on start acceptance
busy  output  1  job in progress
valid  output  1  offw/offd/sh/neg/last are valid
ready  input  1  consumer accepts the current beat
offw  output  BWP  weight bit index
offd  output  BWP  data bit index
sh  output  1  this beat opens a new diagonal (k>0); accumulator shifts before adding
neg  output  1  partial product must be subtracted
last  output  1  final beat of the job
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (clr=1, asynchronous): all outputs are 0 and internal state is IDLE; clr overrides every other input and aborts any job in progress with no done pulse.
- States:
  - IDLE: busy=0, valid=0.
  - RUN: busy=1, valid=1.
  - FIN: done=1, busy=0, valid=0, lasting one cycle, then returns to IDLE.
- Start in IDLE with pw>=1 and pd>=1: latch pw, pd, sw, sd. The next cycle enters RUN with the first pair (offw=0, offd=0), sh=0. Start-to-first-valid latency is 1 cycle.
- Start in IDLE with pw=0 or pd=0: enter FIN directly, emit no beats; done pulses the next cycle.
- start while busy=1 is ignored. start during FIN (busy=0) is accepted, so back-to-back jobs lose exactly one cycle.
- Beat advance: only when valid && ready. With ready=0, all outputs hold stable.
- Walk order: diagonal k runs 0..pw+pd-2. Within diagonal k, offw descends from min(k, pw-1) to max(0, k-pd+1), with offd = k - offw.
  - Every emitted pair satisfies offw<pw and offd<pd.
  - Total beats = pw*pd.
- sh=1 exactly on the first beat of every diagonal k>=1.
- last=1 on the beat (pw-1, pd-1).
- neg = (sw && offw==pw-1) XOR (sd && offd==pd-1).
- Acceptance of the last beat: the next cycle is FIN, with valid=0 and done=1.
- Arithmetic: internal k and bound computations are BWP+1 bits wide and never wrap for any pw, pd <= 2^BWP-1. All outputs are registered (no combinational input-to-output path), including valid's dependence on ready.

Optional Feature:
ZIGZAG_MSB_FIRST_EN:
- Defined: diagonals are walked from k=pw+pd-2 down to 0.
  - Within a diagonal the order is unchanged (offw descending).
  - The first beat is (pw-1, pd-1) and the last beat is (0, 0).
  - sh marks the first beat of every diagonal after the first and means a left shift.
  - The neg rule is unchanged.
- Undefined: LSB-first order as specified above.
- Beat count and handshake timing are identical in both builds.

Test Plan:
1. pw=2, pd=2, sw=sd=0, ready=1: beats (0,0),(1,0),(0,1),(1,1) on the 4 cycles after start; sh=0,1,0,1; last only on beat 4; done the following cycle; busy high for exactly 4 cycles.
2. pw=3, pd=1: beats (0,0),(1,0),(2,0), sh=0,1,1, no offd>0. Then pw=1, pd=3: beats (0,0),(0,1),(0,2), sh=0,1,1.
3. pw=15, pd=15, random ready: 225 accepted beats; all 225 pairs are distinct and in range; offw+offd is non-decreasing; outputs are stable while ready=0; done pulses once.
4. pw=2, pd=2, sw=1, sd=1: neg = 0,1,1,0 for the beats of scenario 1.
5. pw=0, pd=4: no valid, done one cycle after start. Then start during FIN with pw=pd=1: single beat (0,0) with last=1.
6. clr asserted asynchronously mid-job (pw=4, pd=4, after 5 beats): busy, valid and done drop to 0 immediately, no done pulse. A new start with pw=pd=2 then reproduces scenario 1 exactly. Repeat scenarios 1 and 4 with ZIGZAG_MSB_FIRST_EN defined: beats (1,1),(1,0),(0,1),(0,0), sh=0,1,0,1.
